// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and per-register pending-write scoreboard for the single
// register-file write port. Round-robin grant among producers, registered
// write stage, 2-bit saturating-with-error pending counts for hazard stalls.
module regfile_wb_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]      req_ovf,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 rsv_valid,
    input  logic [4:0]           rsv_addr,
    input  logic [4:0]           q_addr1,
    input  logic [4:0]           q_addr2,
    output logic                 q_busy1,
    output logic                 q_busy2,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 rf_commit,
    output logic                 sb_err
);

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned PW   = 2;
    localparam int unsigned CW   = 2;
    localparam int unsigned NREG = 32;

    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic           rf_we_q, rf_we_d;
    logic [AW-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]  rf_wdata_q, rf_wdata_d;
    logic           rf_commit_q, rf_commit_d;
    logic           sb_err_q, sb_err_d;
    logic [CW-1:0]  cnt_q [NREG];
    logic [CW-1:0]  cnt_d [NREG];

    logic [NREQ-1:0] gnt_c;
    logic            found_c;
    logic [PW-1:0]   win_c;
    logic [PW:0]     sum_c;
    logic [AW-1:0]   g_addr_c;
    logic [DW-1:0]   g_data_c;
    logic            g_ovf_c;
    logic            err_c;
    logic            inc_c;
    logic            dec_c;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping at NREQ
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        sum_c   = '0;
        gnt_c   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum_c = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (sum_c >= (PW+1)'(NREQ)) begin
                sum_c = sum_c - (PW+1)'(NREQ);
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found_c && req_valid[i] && (sum_c[PW-1:0] == PW'(i))) begin
                    found_c = 1'b1;
                    win_c   = PW'(i);
                end
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            gnt_c[i] = found_c && (win_c == PW'(i));
        end
    end

    // Select the winning requester's payload
    always_comb begin
        g_addr_c = '0;
        g_data_c = '0;
        g_ovf_c  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                g_addr_c = req_addr[AW*i +: AW];
                g_data_c = req_data[DW*i +: DW];
                g_ovf_c  = req_ovf[i];
            end
        end
    end

    // Grant outputs, forced low during reset
    assign req_ready = rst ? gnt_c : '0;

    // Next state for pointer and write stage
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        rf_commit_d = 1'b0;
        if (found_c) begin
            rf_we_d     = (g_addr_c != '0);
            rf_waddr_d  = g_addr_c;
            rf_wdata_d  = g_data_c;
            rf_commit_d = ~g_ovf_c;
            rr_ptr_d    = (win_c == PW'(NREQ-1)) ? '0 : win_c + PW'(1);
        end
    end

    // Scoreboard next state: reserve increments, grant decrements, same-cycle pair cancels
    always_comb begin
        err_c    = 1'b0;
        inc_c    = 1'b0;
        dec_c    = 1'b0;
        cnt_d[0] = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            inc_c    = rsv_valid && (rsv_addr == AW'(r));
            dec_c    = found_c && (g_addr_c == AW'(r));
            if (inc_c && !dec_c) begin
                if (cnt_q[r] == CW'(3)) begin
                    err_c = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + CW'(1);
                end
            end else if (dec_c && !inc_c) begin
                if (cnt_q[r] == '0) begin
                    err_c = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CW'(1);
                end
            end
        end
        sb_err_d = sb_err_q | err_c;
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            rf_commit_q <= 1'b0;
            sb_err_q    <= 1'b0;
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            rf_commit_q <= rf_commit_d;
            sb_err_q    <= sb_err_d;
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign rf_commit = rf_commit_q;
    assign sb_err    = sb_err_q;
    assign q_busy1   = (cnt_q[q_addr1] != '0);
    assign q_busy2   = (cnt_q[q_addr2] != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for the write-back arbiter: directed scenarios followed by random
// traffic, all checked against a count-based reference model.
module tb_regfile_wb_arbiter;

    localparam int unsigned N = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      valid;
    logic [5*N-1:0]    req_addr;
    logic [32*N-1:0]   req_data;
    logic [N-1:0]      req_ovf;
    logic [N-1:0]      req_ready;
    logic              rsv_valid;
    logic [4:0]        rsv_addr;
    logic [4:0]        q_addr1, q_addr2;
    logic              q_busy1, q_busy2;
    logic              rf_we, rf_commit, sb_err;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;

    logic [4:0]        a [N];
    logic [31:0]       d [N];
    logic              o [N];

    // reference model state
    int                m_cnt [32];
    int                m_ptr;
    int                m_win;
    bit                m_err;
    bit                m_we, m_commit;
    logic [4:0]        m_waddr;
    logic [31:0]       m_wdata;

    // last-sampled outputs
    logic [N-1:0]      obs_ready;
    logic              obs_we, obs_commit, obs_busy1, obs_err;

    int                n_chk = 0;
    int                n_err = 0;
    int                rsvq [$];

    regfile_wb_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ovf   (req_ovf),
        .req_ready (req_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .q_addr1   (q_addr1),
        .q_addr2   (q_addr2),
        .q_busy1   (q_busy1),
        .q_busy2   (q_busy2),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_commit (rf_commit),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    // pack per-requester stimulus onto the flat buses
    always_comb begin
        req_addr = '0;
        req_data = '0;
        req_ovf  = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[5*i +: 5]  = a[i];
            req_data[32*i +: 32] = d[i];
            req_ovf[i]           = o[i];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_ptr = 0; m_win = -1; m_err = 0;
        m_we = 0; m_commit = 0; m_waddr = '0; m_wdata = '0;
    endtask

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w, inc, dec;
        if (!rst) begin
            model_reset();
            return;
        end
        w = model_winner();
        if (w >= 0) begin
            m_we     = (a[w] != 0);
            m_waddr  = a[w];
            m_wdata  = d[w];
            m_commit = !o[w];
            m_ptr    = (w + 1) % N;
        end else begin
            m_we     = 0;
            m_commit = 0;
        end
        inc = (rsv_valid && rsv_addr != 0) ? int'(rsv_addr) : 0;
        dec = (w >= 0 && a[w] != 0) ? int'(a[w]) : 0;
        if (!(inc != 0 && inc == dec)) begin
            if (inc != 0) begin
                if (m_cnt[inc] == 3) m_err = 1; else m_cnt[inc]++;
            end
            if (dec != 0) begin
                if (m_cnt[dec] == 0) m_err = 1; else m_cnt[dec]--;
            end
        end
        m_win = w;
    endtask

    // compare all outputs mid-cycle, then advance model at the rising edge
    task automatic cycle();
        int w;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        w = model_winner();
        exp_ready = (rst && w >= 0) ? N'(1 << w) : '0;
        obs_ready  = req_ready;
        obs_we     = rf_we;
        obs_commit = rf_commit;
        obs_busy1  = q_busy1;
        obs_err    = sb_err;
        check_val("req_ready", req_ready, exp_ready);
        check_val("q_busy1", q_busy1, m_cnt[q_addr1] != 0);
        check_val("q_busy2", q_busy2, m_cnt[q_addr2] != 0);
        check_val("sb_err", sb_err, m_err);
        check_val("rf_we", rf_we, m_we);
        check_val("rf_commit", rf_commit, m_commit);
        check_val("rf_waddr", rf_waddr, m_waddr);
        check_val("rf_wdata", rf_wdata, m_wdata);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic reserve(input int r);
        rsv_valid = 1'b1;
        rsv_addr  = 5'(r);
        cycle();
        rsv_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; valid = '0; rsv_valid = 1'b0; rsv_addr = '0;
        q_addr1 = '0; q_addr2 = '0;
        for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; o[i] = 1'b0; end
        model_reset();

        // reset held with toggling inputs
        for (int k = 0; k < 4; k++) begin
            valid = N'($urandom); rsv_valid = 1'($urandom); rsv_addr = 5'($urandom);
            q_addr1 = 5'($urandom); q_addr2 = 5'($urandom);
            for (int i = 0; i < N; i++) begin a[i] = 5'($urandom); d[i] = $urandom; o[i] = 1'($urandom); end
            cycle();
        end
        valid = 3'b111;
        #1;
        check_val("rst_ready", req_ready, 0);
        valid = '0; rsv_valid = 1'b0; q_addr1 = '0; q_addr2 = '0;
        rst = 1'b1;
        cycle(); cycle();

        // round-robin fairness on r5/r6/r7
        for (int rep = 0; rep < 2; rep++)
            for (int r = 5; r <= 7; r++) reserve(r);
        for (int i = 0; i < N; i++) begin a[i] = 5'(5 + i); d[i] = $urandom; o[i] = 1'b0; end
        valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check_val("rr_order", obs_ready, 1 << (k % 3));
        end
        valid = '0;
        cycle();

        // overflow-cancelled write
        reserve(8);
        q_addr1 = 5'd8;
        valid = 3'b001; a[0] = 5'd8; d[0] = 32'hDEADBEEF; o[0] = 1'b1;
        cycle();
        valid = '0; o[0] = 1'b0;
        cycle();
        check_val("ovf_we", obs_we, 1);
        check_val("ovf_commit", obs_commit, 0);
        check_val("ovf_busy", obs_busy1, 0);

        // write to $0
        reserve(0);
        valid = 3'b010; a[1] = 5'd0; d[1] = 32'h12345678;
        cycle();
        check_val("zero_ready", obs_ready, 3'b010);
        valid = '0;
        cycle();
        check_val("zero_we", obs_we, 0);
        check_val("zero_err", obs_err, 0);

        // scoreboard saturation, cancel and drain on r9
        q_addr1 = 5'd9;
        reserve(9); reserve(9); reserve(9);
        cycle();
        check_val("sb_busy", obs_busy1, 1);
        reserve(9);
        cycle();
        check_val("sb_ovr_err", obs_err, 1);
        valid = 3'b001; a[0] = 5'd9; d[0] = $urandom;
        reserve(9);
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (k == 2) check_val("sb_hold", obs_busy1, 1);
        end
        valid = '0;
        cycle();
        check_val("sb_drain", obs_busy1, 0);

        // reset in the middle of a write
        reserve(20); reserve(20);
        q_addr1 = 5'd20;
        valid = 3'b100; a[2] = 5'd20; d[2] = $urandom;
        cycle();
        valid = '0;
        check_val("mf_we_pre", rf_we, 1);
        #2;
        rst = 1'b0;
        #1;
        check_val("mf_we_async", rf_we, 0);
        check_val("mf_busy", q_busy1, 0);
        check_val("mf_err", sb_err, 0);
        model_reset();
        cycle(); cycle();
        rst = 1'b1;
        for (int i = 0; i < N; i++) a[i] = '0;
        valid = 3'b111;
        cycle();
        check_val("mf_rr_restart", obs_ready, 3'b001);
        valid = '0;
        cycle();

        // random traffic: producers write back registers reserved earlier
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++)
                if (valid[i] && m_win == i) valid[i] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!valid[i] && $urandom_range(0, 1) == 1) begin
                    valid[i] = 1'b1;
                    if (rsvq.size() > 0 && $urandom_range(0, 7) != 0) a[i] = 5'(rsvq.pop_front());
                    else a[i] = '0;
                    d[i] = $urandom;
                    o[i] = ($urandom_range(0, 7) == 0);
                end
            end
            rsv_valid = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                int r;
                r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : int'($urandom_range(1, 7));
                if (m_cnt[r] < 3) begin
                    rsv_valid = 1'b1;
                    rsv_addr  = 5'(r);
                    rsvq.push_back(r);
                end
            end
            q_addr1 = 5'($urandom_range(0, 7));
            q_addr2 = 5'($urandom_range(0, 31));
            cycle();
        end
        valid = '0; rsv_valid = 1'b0;
        cycle(); cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
